// File: rtl/aes_dec_pkg.sv
// Shared helpers for the iterative AES inverse cipher: inverse S-box,
// GF(2^8) constant multipliers, FSM encoding and the round-count limit.
package aes_dec_pkg;

    localparam int unsigned NR_MAX = 14;

    typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

    // Byte 0x00 sits in the top byte, so entry x lives at bit offset 8*(255-x).
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(gf_mul2(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        return gf_mul2(gf_mul2(gf_mul2(b))) ^ gf_mul2(gf_mul2(b)) ^ gf_mul2(b);
    endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
// last=1 drops InvMixColumns for the final round.
module aes_inv_round_comb
    import aes_dec_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next_state
);

    logic [127:0] ak;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
                gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
                gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
                gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
    endfunction

    // Byte r+4c (row r, column c) is at the MSB end for index 0; row r pulls from column c-r.
    always_comb begin
        ak = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ak[8*(15-(r+4*c)) +: 8] =
                    inv_sbox(state[8*(15-(r+4*((c-r+4)%4))) +: 8]) ^ rk[8*(15-(r+4*c)) +: 8];
            end
        end
    end

    always_comb begin
        next_state = ak;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                next_state[32*(3-c) +: 32] = inv_mix_col(ak[32*(3-c) +: 32]);
            end
        end
    end

endmodule

// File: rtl/aes_dec_iter.sv
// Iterative AES inverse cipher sharing one inverse round over NR passes.
// Define AES_DEC_CBC_EN to add CBC chaining (iv_we/iv_data ports and chain register).
module aes_dec_iter
    import aes_dec_pkg::*;
#(
    parameter int unsigned NR = 10,
    parameter int unsigned KW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_we,
    input  logic [KW-1:0] key_addr,
    input  logic [127:0]  key_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy
`ifdef AES_DEC_CBC_EN
    ,
    input  logic          iv_we,
    input  logic [127:0]  iv_data
`endif
);

    fsm_e          fsm_q, fsm_d;
    logic [127:0]  blk_q;
    logic [127:0]  cin_q;
    logic [127:0]  round_out;
    logic [KW-1:0] rnd_q;
    logic [127:0]  rk_q [NR+1];
    logic          accept;
    logic          iv_load;

    assign accept = in_valid && in_ready;

`ifdef AES_DEC_CBC_EN
    logic [127:0] chain_q;
    logic         done_hs;

    assign iv_load = iv_we && (fsm_q == StIdle);
    assign done_hs = (fsm_q == StDone) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else if (iv_load) begin
            chain_q <= iv_data;
        end else if (done_hs) begin
            chain_q <= cin_q;
        end
    end

    assign out_data = blk_q ^ chain_q;
`else
    assign iv_load  = 1'b0;
    assign out_data = blk_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= StIdle;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            StIdle:  if (accept) fsm_d = StRound;
            StRound: if (rnd_q == '0) fsm_d = StDone;
            StDone:  if (out_ready) fsm_d = accept ? StRound : StIdle;
            default: fsm_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (fsm_q)
            StIdle:  in_ready = !iv_load;
            StRound: busy = 1'b1;
            StDone: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Key file is frozen while rounds are in flight; out-of-range indices are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NR + 1; i++) begin
                rk_q[i] <= '0;
            end
        end else if (key_we && (fsm_q != StRound) && (key_addr <= KW'(NR))) begin
            rk_q[key_addr] <= key_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_q <= '0;
            cin_q <= '0;
            rnd_q <= '0;
        end else if (accept) begin
            blk_q <= in_data ^ rk_q[NR];
            cin_q <= in_data;
            rnd_q <= KW'(NR - 1);
        end else if (fsm_q == StRound) begin
            blk_q <= round_out;
            if (rnd_q != '0) begin
                rnd_q <= rnd_q - KW'(1);
            end
        end
    end

    aes_inv_round_comb u_round (
        .state      (blk_q),
        .rk         (rk_q[rnd_q]),
        .last       (rnd_q == '0),
        .next_state (round_out)
    );

endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed bench for aes_dec_iter using the FIPS-197 C.1 AES-128 vector.
// Build with AES_DEC_CBC_EN to also exercise the CBC chain.
module tb_aes_dec_iter;

    localparam int unsigned NR = 10;
    localparam int unsigned KW = 4;
    localparam logic [127:0] CT      = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BAD_KEY = 128'hdeadbeef0badf00dcafebabe12345678;

    logic [127:0] c1_keys [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    logic          clk = 1'b0;
    logic          rst;
    logic          key_we;
    logic [KW-1:0] key_addr;
    logic [127:0]  key_data;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;
    logic          busy;
`ifdef AES_DEC_CBC_EN
    logic          iv_we;
    logic [127:0]  iv_data;
`endif

    int           n_total = 0;
    int           n_bad   = 0;
    int           cyc     = 0;
    int           t0;
    int           acc [3];
    int           n_acc;
    int           n_out;
    int           n_seen;
    int           n_unstable;
    logic [127:0] hold_data;
    logic [127:0] chain_m;

    aes_dec_iter #(
        .NR (NR),
        .KW (KW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_we    (key_we),
        .key_addr  (key_addr),
        .key_data  (key_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef AES_DEC_CBC_EN
        ,
        .iv_we     (iv_we),
        .iv_data   (iv_data)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // All tasks are entered just after a falling edge and leave just after one.
    task automatic load_keys();
        for (int i = 0; i <= 10; i++) begin
            key_we   = 1'b1;
            key_addr = KW'(i);
            key_data = c1_keys[i];
            @(negedge clk);
        end
        key_we = 1'b0;
    endtask

    task automatic start_block(input logic [127:0] ct, input string tag, output int t_acc);
        in_valid = 1'b1;
        in_data  = ct;
        check_eq({tag, " in_ready"}, 128'(in_ready), 128'(1));
        t_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int t_acc, input logic [127:0] exp, input string tag);
        int k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, " out_valid"}, 128'(out_valid), 128'(1));
        check_eq({tag, " latency"}, 128'(cyc - t_acc - 1), 128'(NR));
        check_eq({tag, " out_data"}, out_data, exp);
    endtask

    // Single C.1 block with out_ready held high; chain_m tracks the CBC chain.
    task automatic run_block(input string tag);
        int t_acc;
        start_block(CT, tag, t_acc);
        wait_out(t_acc, PT ^ chain_m, tag);
        @(negedge clk);
`ifdef AES_DEC_CBC_EN
        chain_m = CT;
`endif
    endtask

    initial begin
        rst       = 1'b1;
        key_we    = 1'b0;
        key_addr  = '0;
        key_data  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        chain_m   = '0;
`ifdef AES_DEC_CBC_EN
        iv_we     = 1'b0;
        iv_data   = '0;
`endif
        repeat (2) @(negedge clk);
        check_eq("reset in_ready", 128'(in_ready), 128'(1));
        check_eq("reset out_valid", 128'(out_valid), 128'(0));
        check_eq("reset busy", 128'(busy), 128'(0));
        check_eq("reset out_data", out_data, 128'(0));
        rst = 1'b0;
        @(negedge clk);

        load_keys();
        run_block("c1");

        // Back-to-back: in_valid held, three accepts spaced by NR+1 cycles.
        n_acc = 0;
        n_out = 0;
        for (int i = 0; i < 60 && n_out < 3; i++) begin
            in_valid = (n_acc < 3);
            in_data  = CT;
            if (out_valid) begin
                check_eq("b2b out_data", out_data, PT ^ chain_m);
                check_eq("b2b in_ready in done", 128'(in_ready), 128'(1));
`ifdef AES_DEC_CBC_EN
                chain_m = CT;
`endif
                n_out++;
            end
            if (in_valid && in_ready && n_acc < 3) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_eq("b2b outputs", 128'(n_out), 128'(3));
        check_eq("b2b gap 1", 128'(acc[1] - acc[0]), 128'(NR + 1));
        check_eq("b2b gap 2", 128'(acc[2] - acc[1]), 128'(NR + 1));

        // Backpressure; rk10 is corrupted at the accepting edge, which must not
        // affect this block, and restored during DONE for the next one.
        out_ready = 1'b0;
        key_we    = 1'b1;
        key_addr  = KW'(10);
        key_data  = BAD_KEY;
        start_block(CT, "bp", t0);
        key_we = 1'b0;
        wait_out(t0, PT ^ chain_m, "bp");
        hold_data  = PT ^ chain_m;
        n_unstable = 0;
        n_seen     = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = ~CT;
            key_we   = (i == 3);
            key_data = c1_keys[10];
            if (!out_valid || out_data !== hold_data) n_unstable++;
            if (in_ready) n_seen++;
            @(negedge clk);
        end
        key_we    = 1'b0;
        in_valid  = 1'b0;
        check_eq("bp unstable cycles", 128'(n_unstable), 128'(0));
        check_eq("bp in_ready cycles", 128'(n_seen), 128'(0));
        out_ready = 1'b1;
        @(negedge clk);
`ifdef AES_DEC_CBC_EN
        chain_m = CT;
`endif
        check_eq("bp release idle", 128'(in_ready), 128'(1));
        run_block("bp next");

        // Writes in ROUND and beyond NR must be dropped.
        start_block(CT, "busy", t0);
        check_eq("busy flag", 128'(busy), 128'(1));
        key_we   = 1'b1;
        key_addr = KW'(10);
        key_data = BAD_KEY;
        @(negedge clk);
        key_we = 1'b0;
        wait_out(t0, PT ^ chain_m, "busy");
        @(negedge clk);
`ifdef AES_DEC_CBC_EN
        chain_m = CT;
`endif
        key_we   = 1'b1;
        key_addr = 4'hf;
        key_data = BAD_KEY;
        @(negedge clk);
        key_we = 1'b0;
        run_block("after drops");

        // Reset during round 5 aborts the block.
        start_block(CT, "rst", t0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("mid rst in_ready", 128'(in_ready), 128'(1));
        check_eq("mid rst out_valid", 128'(out_valid), 128'(0));
        check_eq("mid rst busy", 128'(busy), 128'(0));
        check_eq("mid rst out_data", out_data, 128'(0));
        @(negedge clk);
        rst     = 1'b0;
        chain_m = '0;
        n_seen  = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) n_seen++;
        end
        check_eq("mid rst no out_valid", 128'(n_seen), 128'(0));
        load_keys();
        run_block("post rst");

`ifdef AES_DEC_CBC_EN
        iv_we    = 1'b1;
        iv_data  = '1;
        in_valid = 1'b1;
        in_data  = CT;
        check_eq("iv wins in_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        iv_we    = 1'b0;
        in_valid = 1'b0;
        check_eq("iv wins no accept", 128'(busy), 128'(0));
        start_block(CT, "cbc1", t0);
        wait_out(t0, 128'hffeeddccbbaa99887766554433221100, "cbc1");
        @(negedge clk);
        start_block(CT, "cbc2", t0);
        wait_out(t0, 128'h69d5c2eb2e2e624750541d3bbc692ba5, "cbc2");
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_dec_iter.md
# aes_dec_iter

Iterative, parametrised AES inverse-cipher engine. It decrypts one 128-bit block per pass through a single shared inverse round, reusing that round for all NR rounds. Round keys come from an internal round-key file written by the key-schedule logic. The engine has valid/ready streaming ports so it can sit directly between the ciphertext source and the plaintext sink.

## Interface
- NR, default 10: number of cipher rounds; legal values 10/12/14 (AES-128/192/256 schedules).
- KW, default 4: key_addr width; must satisfy 2^KW >= NR+1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- key_we  input  1  round-key write strobe.
- key_addr  input  KW  round-key index 0..NR.
- key_data  input  128  round key in FIPS-197 byte order.
- in_valid  input  1  ciphertext block offered.
- in_ready  output  1  engine accepts a block this cycle.
- in_data  input  128  ciphertext block.
- out_valid  output  1  plaintext block available.
- out_ready  input  1  sink accepts the plaintext.
- out_data  output  128  plaintext block.
- busy  output  1  high in ROUND state.
- iv_we  input  1  IV load strobe (present only with AES_DEC_CBC_EN).
- iv_data  input  128  IV value (present only with AES_DEC_CBC_EN).

## Operation
- Round-key file: NR+1 registers of 128 bits. A write happens when key_we=1, state is not ROUND and key_addr<=NR. Writes in ROUND, or to key_addr>NR, are dropped silently.
- FSM has three states: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid, the engine captures state <= in_data ^ rk[NR] and cin <= in_data, sets rnd <= NR-1, and goes to ROUND.
- ROUND: each cycle applies one inverse round with rk[rnd]: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns. InvMixColumns is skipped when rnd==0. rnd decrements each cycle. After the rnd==0 round the FSM goes to DONE.
- DONE: out_valid=1 and out_data holds. The FSM leaves DONE on out_ready=1.
  - With in_valid=1 in the same cycle, it accepts the next block directly and goes to ROUND.
  - Otherwise it goes to IDLE.
- in_ready = IDLE, or (DONE and out_ready).
- in_data is never accepted in ROUND.
- ECB output: out_data = final state.
- busy = 1 only in ROUND.

## Timing
- Reset values:
  - state IDLE, in_ready=1, out_valid=0, busy=0.
  - out_data, state, cin, rnd, rk[*] and chain register all zero.
- Latency: out_valid rises on the NR-th rising edge after the accepting edge, which is 10 edges for AES-128.
- Throughput: one block per NR+1 cycles when out_ready is held high; DONE lasts exactly one cycle in that case.
- Backpressure: out_data and out_valid stay stable while out_ready=0. No block is lost or duplicated.
- Reset mid-block aborts the block. No out_valid follows, and the next accepted block decrypts correctly once keys are reloaded.
- Simultaneous key_we and in_valid in IDLE: the key write commits at the same edge. The initial AddRoundKey reads the pre-write rk[NR].

## Configuration
- AES_DEC_CBC_EN defined: CBC decryption.
  - A 128-bit chain register is added.
  - out_data = final state ^ chain. On the DONE exit handshake, chain <= cin.
  - iv_we=1 in IDLE loads chain <= iv_data; iv_we outside IDLE is ignored.
  - If iv_we and in_valid coincide in IDLE, the IV load wins. in_ready is 0 that cycle.
- AES_DEC_CBC_EN undefined: ECB only. iv_we and iv_data are not ports, and no chain register exists.

## Structure
- Package aes_dec_pkg:
  - inverse S-box function.
  - gf_mul2/gf_mul9/11/13/14 functions.
  - FSM state enum.
  - NR_MAX=14 constant.
- Sub-module aes_inv_round_comb: combinational (state, rk, last) -> next_state.
  - last=1 suppresses InvMixColumns.
  - One instance inside aes_dec_iter.

## Test plan
- FIPS-197 C.1, NR=10:
  - Keys: load rk0=000102030405060708090a0b0c0d0e0f and rk10=13111d7fe3944a17f307a78b4d2b30c5, plus the remaining C.1 schedule.
  - Stimulus: in_data=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: out_data=00112233445566778899aabbccddeeff with out_valid on the 10th edge after acceptance.
- Back-to-back: three blocks with out_ready=1 -> accepts spaced exactly 11 cycles apart, each output correct, in_ready high in every DONE cycle.
- Backpressure: out_ready=0 for 20 cycles after DONE -> out_data stable, in_ready=0; a key_we issued during DONE is accepted.
- Busy protections: key_we to rk10 during ROUND, and key_addr=15 in IDLE -> both dropped; a subsequent C.1 block still decrypts correctly.
- Reset: rst pulse at round 5 -> all outputs at reset values, no out_valid; after keys are reloaded, the C.1 block decrypts correctly.
- CBC (AES_DEC_CBC_EN defined):
  - Setup: IV=ffffffffffffffffffffffffffffffff, C.1 ciphertext sent twice.
  - Required: first output ffeeddccbbaa99887766554433221100, second output 69d5c2eb2e2e624750541d3bbc692ba5.
